led7_scan: RTL and testbench
============================

LED7_SCAN -- requirements
Module: led7_scan

Interface
REQ-001 SHALL have parameter DWELL, default 8, number of clock cycles a digit is driven per scan slot (legal range 1 or more).
REQ-002 SHALL have parameter BLANK, default 2, number of dead-time cycles with all digits off before each digit (legal range 1 or more).
REQ-003 SHALL have port i_w_clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port i_w_reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port i_w_value, input, 16 bits, four BCD nibbles, where [3:0] is digit 0 (least significant) and [15:12] is digit 3.
REQ-006 SHALL have port i_w_valid, input, 1 bit, offering i_w_value for load.
REQ-007 SHALL have port o_w_ready, output, 1 bit, the block can accept a value.
REQ-008 SHALL have port i_w_lzb, input, 1 bit, leading-zero blanking enable, sampled each cycle.
REQ-009 SHALL have port o_w_seg, output, 7 bits, active-high segments, bit0=a through bit6=g.
REQ-010 SHALL have port o_w_an, output, 4 bits, active-high one-hot digit enable.
REQ-011 SHALL have port o_w_digit, output, 2 bits, index of the current scan digit.

Function
REQ-012 SHALL hold registers for: state (BLANK_S, SHOW_S), a 2-bit digit index, a cycle counter, a 16-bit active value, a 16-bit pending value, and a pending-full flag.
REQ-013 SHALL apply per-slot sequencing of BLANK_S for BLANK cycles, then SHOW_S for DWELL cycles; each phase's counter SHALL run from 0 to its phase length minus 1, then reset to 0.
REQ-014 SHALL, on the last SHOW_S cycle, enter BLANK_S and increment the digit index modulo 4 (3 wraps to 0); one frame is 4*(BLANK+DWELL) cycles.
REQ-015 SHALL drive o_w_an=4'b0000 and o_w_seg=7'b0000000 in BLANK_S.
REQ-016 SHALL, in SHOW_S, drive o_w_an to a one-hot of the digit index and o_w_seg to the pattern of the active nibble, unless that digit is suppressed.
REQ-017 SHALL use the following segment patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, and 10-15=1111111.
REQ-018 SHALL, when i_w_lzb=1, suppress digit k (k=1..3) if nibbles k through 3 of the active value are all zero; digit 0 is never suppressed.
REQ-019 SHALL drive a suppressed digit in SHOW_S as o_w_an=0000 and o_w_seg=0000000 while timing is unchanged.
REQ-020 SHALL define o_w_ready = NOT pending-full; a transfer occurs on a cycle with i_w_valid=1 and o_w_ready=1.
REQ-021 SHALL, on a transfer, capture i_w_value into the pending register and set pending-full on the next edge.
REQ-022 SHALL treat the last SHOW_S cycle of digit 3 as the frame boundary: if pending-full, copy pending to active and clear pending-full, so the new value first appears at digit 0 of the next frame.
REQ-023 SHALL, when a transfer and the frame boundary coincide with pending empty, load i_w_value directly into active and leave pending-full clear.
REQ-024 SHALL make a held i_w_valid with o_w_ready=0 cause no state change; the value SHALL be neither dropped nor overwritten.
REQ-025 SHALL derive all outputs from registers and i_w_lzb only, with no combinational path from i_w_value or i_w_valid.

Reset
REQ-026 SHALL, while i_w_reset=1, force state=BLANK_S, digit=0, counter=0, active=0, pending=0, and pending-full=0, immediately and independent of the clock.
REQ-027 SHALL, during reset, drive o_w_an=0000, o_w_seg=0000000, o_w_digit=00, and o_w_ready=1.
REQ-028 SHALL, when reset is asserted mid-frame or mid-transfer, discard all in-flight data; the first post-reset slot SHALL be digit 0 starting with a full BLANK phase.

Verification (DWELL=3, BLANK=1)
REQ-029 SHALL cover release from reset with lzb=0: cycle 0 gives an=0000; cycles 1-3 give an=0001, seg=0111111; cycle 4 gives an=0000, digit=1; frame repeats every 16 cycles.
REQ-030 SHALL cover a mid-frame load of 16'h1234: ready falls next cycle and the old value displays until the boundary; the next frame shows digit0 seg=1100110 and digit3 seg=0000110; ready returns to 1 after the boundary.
REQ-031 SHALL cover back-to-back valid of 16'h1111 then 16'h2222: the second is held with ready=0 until the boundary; the frame after 1111 shows 2222 (seg=1011011 on all digits).
REQ-032 SHALL cover lzb=1 with value 16'h0007: only digit 0 is enabled (an=0001, seg=0000111); digits 1-3 give an=0000, seg=0000000; value 16'h0070 also enables digit 1.
REQ-033 SHALL cover value 16'hA000 with lzb=1: digit 3 shows seg=1111111 and digits 2-0 show 0111111 (not suppressed).
REQ-034 SHALL cover reset pulsed during SHOW_S of digit 2 with pending full: outputs clear asynchronously, ready=1, and the first post-reset frame shows 0000.

Source files
------------

// File: rtl/led7_scan.sv
// led7_scan: multiplexed 4-digit 7-segment display driver.
//
// Each digit gets a slot of BLANK dead-time cycles (all outputs off) followed
// by DWELL cycles with the digit driven. A new value is offered through a
// valid/ready handshake into a one-deep pending register. It is promoted to
// the active value only at the end of a frame, so a frame never mixes two
// values.
//
// Ports:
//   i_w_clk    - clock, rising edge
//   i_w_reset  - asynchronous active-high reset
//   i_w_value  - four BCD nibbles, [3:0] is digit 0
//   i_w_valid  - i_w_value is offered for load
//   o_w_ready  - a value can be accepted (pending register empty)
//   i_w_lzb    - leading-zero blanking enable
//   o_w_seg    - active-high segments, bit0=a .. bit6=g
//   o_w_an     - active-high one-hot digit enable
//   o_w_digit  - index of the digit currently being scanned
module led7_scan #(
    parameter int unsigned DWELL = 8,
    parameter int unsigned BLANK = 2
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset,
    input  logic [15:0] i_w_value,
    input  logic        i_w_valid,
    output logic        o_w_ready,
    input  logic        i_w_lzb,
    output logic [6:0]  o_w_seg,
    output logic [3:0]  o_w_an,
    output logic [1:0]  o_w_digit
);

    localparam int unsigned MaxLen = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [1:0]      digit_q, digit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     active_q, active_d;
    logic [15:0]     pending_q, pending_d;
    logic            pend_full_q, pend_full_d;

    logic show_last;
    logic frame_end;
    logic xfer;

    assign o_w_ready = ~pend_full_q;
    assign o_w_digit = digit_q;
    assign xfer      = i_w_valid & ~pend_full_q;
    assign show_last = (state_q == StShow) && (cnt_q == DwellLast);
    assign frame_end = show_last && (digit_q == 2'd3);

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state_q     <= StBlank;
            digit_q     <= 2'd0;
            cnt_q       <= '0;
            active_q    <= 16'h0000;
            pending_q   <= 16'h0000;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Scan sequencing and value promotion.
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShow: begin
                if (show_last) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        if (frame_end) begin
            if (pend_full_q) begin
                active_d    = pending_q;
                pend_full_d = 1'b0;
            end else if (xfer) begin
                // Empty pending at the boundary: skip the pending stage.
                active_d = i_w_value;
            end
        end else if (xfer) begin
            pending_d   = i_w_value;
            pend_full_d = 1'b1;
        end
    end

    logic [3:0] nibble;
    logic       suppress;

    always_comb begin
        nibble   = active_q[3:0];
        suppress = 1'b0;
        case (digit_q)
            2'd0: nibble = active_q[3:0];
            2'd1: begin
                nibble   = active_q[7:4];
                suppress = i_w_lzb && (active_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble   = active_q[11:8];
                suppress = i_w_lzb && (active_q[15:8] == 8'h00);
            end
            default: begin
                nibble   = active_q[15:12];
                suppress = i_w_lzb && (active_q[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        o_w_an  = 4'b0000;
        o_w_seg = 7'b0000000;
        if ((state_q == StShow) && !suppress) begin
            o_w_an = 4'b0001 << digit_q;
            case (nibble)
                4'd0:    o_w_seg = 7'b0111111;
                4'd1:    o_w_seg = 7'b0000110;
                4'd2:    o_w_seg = 7'b1011011;
                4'd3:    o_w_seg = 7'b1001111;
                4'd4:    o_w_seg = 7'b1100110;
                4'd5:    o_w_seg = 7'b1101101;
                4'd6:    o_w_seg = 7'b1111101;
                4'd7:    o_w_seg = 7'b0000111;
                4'd8:    o_w_seg = 7'b1111111;
                4'd9:    o_w_seg = 7'b1100111;
                default: o_w_seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_led7_scan.sv
// Bench for led7_scan with DWELL=3, BLANK=1: a reset-release vector table,
// directed load / blanking / reset sequences, then random traffic checked
// against a time-based reference model.
module tb_led7_scan;

    localparam int unsigned DWELL = 3;
    localparam int unsigned BLANK = 1;
    localparam int SLOT  = BLANK + DWELL;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        valid;
    logic        ready;
    logic        lzb;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit;

    always #5 clk = ~clk;

    led7_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .i_w_value (value),
        .i_w_valid (valid),
        .o_w_ready (ready),
        .i_w_lzb   (lzb),
        .o_w_seg   (seg),
        .o_w_an    (an),
        .o_w_digit (digit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles since reset, displayed value, pending queue.
    int          t_m;
    logic [15:0] act_m;
    logic [15:0] pend_m[$];
    logic [6:0]  lut[16];

    typedef struct {
        logic        v;
        logic [15:0] val;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [1:0]  dig;
        logic        rdy;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t_m);
        end
    endtask

    task automatic model_check();
        int          ph;
        int          dg;
        logic        show;
        logic        supp;
        logic [15:0] upper;
        logic [3:0]  nib;
        ph    = t_m % SLOT;
        dg    = (t_m / SLOT) % 4;
        show  = (ph >= BLANK);
        upper = act_m >> (4 * dg);
        nib   = upper[3:0];
        supp  = lzb && (dg != 0) && (upper == 16'h0);
        chk("model_an", 16'(an), (show && !supp) ? 16'(1 << dg) : 16'h0);
        chk("model_seg", 16'(seg), (show && !supp) ? 16'(lut[nib]) : 16'h0);
        chk("model_digit", 16'(digit), 16'(dg));
        chk("model_ready", 16'(ready), 16'(pend_m.size() == 0));
    endtask

    // Drive inputs at a negedge, check, then advance model by one clock.
    task automatic cycle(input logic v, input logic [15:0] val);
        logic rdy;
        logic xfer;
        logic bnd;
        valid = v;
        value = val;
        #1;
        model_check();
        @(posedge clk);
        rdy  = (pend_m.size() == 0);
        xfer = v && rdy;
        bnd  = ((t_m % FRAME) == FRAME - 1);
        if (bnd) begin
            if (!rdy) act_m = pend_m.pop_front();
            else if (xfer) act_m = val;
        end else if (xfer) begin
            pend_m.push_back(val);
        end
        t_m++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom));
    endtask

    task automatic chk_now(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic rdy_e);
        #1;
        chk({name, "_an"}, 16'(an), 16'(an_e));
        chk({name, "_seg"}, 16'(seg), 16'(seg_e));
        chk({name, "_ready"}, 16'(ready), 16'(rdy_e));
    endtask

    // Called at a negedge; reset rises between edges to show it is asynchronous.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_an", 16'(an), 16'h0);
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_digit", 16'(digit), 16'h0);
        chk("rst_ready", 16'(ready), 16'h1);
        @(negedge clk);
        rst   = 1'b0;
        t_m   = 0;
        act_m = 16'h0;
        pend_m.delete();
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        value = 16'h0;
        lzb   = 1'b0;
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h67, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        tbl = '{
            '{1'b0, 16'h0, 4'h0, 7'h00, 2'd0, 1'b1},
            '{1'b0, 16'h0, 4'h1, 7'h3F, 2'd0, 1'b1},
            '{1'b0, 16'h0, 4'h1, 7'h3F, 2'd0, 1'b1},
            '{1'b0, 16'h0, 4'h1, 7'h3F, 2'd0, 1'b1},
            '{1'b0, 16'h0, 4'h0, 7'h00, 2'd1, 1'b1},
            '{1'b0, 16'h0, 4'h2, 7'h3F, 2'd1, 1'b1},
            '{1'b0, 16'h0, 4'h2, 7'h3F, 2'd1, 1'b1},
            '{1'b0, 16'h0, 4'h2, 7'h3F, 2'd1, 1'b1},
            '{1'b0, 16'h0, 4'h0, 7'h00, 2'd2, 1'b1},
            '{1'b0, 16'h0, 4'h4, 7'h3F, 2'd2, 1'b1},
            '{1'b0, 16'h0, 4'h4, 7'h3F, 2'd2, 1'b1},
            '{1'b0, 16'h0, 4'h4, 7'h3F, 2'd2, 1'b1},
            '{1'b0, 16'h0, 4'h0, 7'h00, 2'd3, 1'b1},
            '{1'b0, 16'h0, 4'h8, 7'h3F, 2'd3, 1'b1},
            '{1'b0, 16'h0, 4'h8, 7'h3F, 2'd3, 1'b1},
            '{1'b0, 16'h0, 4'h8, 7'h3F, 2'd3, 1'b1},
            '{1'b0, 16'h0, 4'h0, 7'h00, 2'd0, 1'b1}
        };
        t_m   = 0;
        act_m = 16'h0;
        @(negedge clk);

        // Release from reset, lzb=0: frame repeats every 16 cycles.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            valid = tbl[i].v;
            value = tbl[i].val;
            #1;
            chk("tbl_an", 16'(an), 16'(tbl[i].an));
            chk("tbl_seg", 16'(seg), 16'(tbl[i].seg));
            chk("tbl_digit", 16'(digit), 16'(tbl[i].dig));
            chk("tbl_ready", 16'(ready), 16'(tbl[i].rdy));
            cycle(tbl[i].v, tbl[i].val);
        end

        // Mid-frame load of 1234.
        do_reset();
        idle(5);
        cycle(1'b1, 16'h1234);
        chk_now("load_ready_low", 4'h2, 7'h3F, 1'b0);
        idle(10);
        chk_now("load_boundary", 4'h0, 7'h00, 1'b1);
        idle(1);
        chk_now("load_dig0", 4'h1, 7'h66, 1'b1);
        idle(12);
        chk_now("load_dig3", 4'h8, 7'h06, 1'b1);

        // Back-to-back 1111 then 2222 held while not ready.
        do_reset();
        cycle(1'b1, 16'h1111);
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'h2222);
        chk_now("b2b_1111", 4'h1, 7'h06, 1'b0);
        idle(16);
        chk_now("b2b_2222_d0", 4'h1, 7'h5B, 1'b1);
        idle(12);
        chk_now("b2b_2222_d3", 4'h8, 7'h5B, 1'b1);

        // Leading-zero blanking.
        lzb = 1'b1;
        do_reset();
        cycle(1'b1, 16'h0007);
        idle(16);
        chk_now("lzb7_d0", 4'h1, 7'h07, 1'b1);
        idle(4);
        chk_now("lzb7_d1", 4'h0, 7'h00, 1'b1);
        chk("lzb7_digit", 16'(digit), 16'h1);
        cycle(1'b1, 16'h0070);
        idle(15);
        chk_now("lzb70_d1", 4'h2, 7'h07, 1'b1);
        idle(8);
        chk_now("lzb70_d3", 4'h0, 7'h00, 1'b1);

        do_reset();
        cycle(1'b1, 16'hA000);
        idle(16);
        chk_now("a000_d0", 4'h1, 7'h3F, 1'b1);
        idle(8);
        chk_now("a000_d2", 4'h4, 7'h3F, 1'b1);
        idle(4);
        chk_now("a000_d3", 4'h8, 7'h7F, 1'b1);

        // Reset during SHOW of digit 2 with pending full.
        lzb = 1'b0;
        do_reset();
        cycle(1'b1, 16'h5555);
        idle(15);
        cycle(1'b1, 16'h6666);
        idle(8);
        chk_now("pre_rst_d2", 4'h4, 7'h6D, 1'b0);
        do_reset();
        idle(1);
        chk_now("post_rst_d0", 4'h1, 7'h3F, 1'b1);
        idle(12);
        chk_now("post_rst_d3", 4'h8, 7'h3F, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) lzb = ~lzb;
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 1) == 0)
                cycle(($urandom_range(0, 2) == 0), 16'($urandom) & 16'h0F0F);
            else
                cycle(($urandom_range(0, 2) == 0), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
